vc_fifo_bank: RTL

//  Bank of VC_NUM independent circular FIFOs (one per virtual channel) behind one shared write port and one shared read port.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/vc_fifo_ctrl.sv | 68 ++++++
 rtl/vc_fifo_bank.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants, width helpers and VC id type
//
// Purpose: compile-time helpers shared by the VC FIFO bank files.
// Ports:   none (package).
package noc_pkg;

  // Flit width used as the default data width of router input buffers.
  localparam int FLIT_W     = 8;
  localparam int VC_NUM_DEF = 2;

  // Ceiling log2, constant-evaluable.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Width of a select field for n items; never narrower than one bit.
  function automatic int vc_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int VC_W_DEF = vc_w(VC_NUM_DEF);

  typedef logic [VC_W_DEF-1:0] vc_id_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// rtl/vc_fifo_ctrl.sv - per-VC pointer, status and accept/error control
//
// Purpose: pointer bookkeeping for one virtual channel of the FIFO bank.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_req_i, rd_req_i      write/read request already decoded for this VC
//   wr_acc_o, rd_acc_o      request accepted this cycle
//   wr_idx_o, rd_idx_o      storage slot index of tail / head
//   full_o, empty_o, afull_o, count_o   status from registered pointers
//   overflow_o, underflow_o one-cycle pulses for rejected requests
module vc_fifo_ctrl #(
  parameter int DEPTH_W   = 2,
  parameter int AFULL_LVL = 3,
  localparam int PW       = DEPTH_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_req_i,
  input  logic               rd_req_i,
  output logic               wr_acc_o,
  output logic               rd_acc_o,
  output logic [DEPTH_W-1:0] wr_idx_o,
  output logic [DEPTH_W-1:0] rd_idx_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               afull_o,
  output logic [PW-1:0]      count_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  // One extra pointer bit distinguishes full from empty so all slots are usable.
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_underflow;

  assign empty_o  = (r_wr_ptr == r_rd_ptr);
  assign full_o   = (r_wr_ptr[DEPTH_W] != r_rd_ptr[DEPTH_W]) &&
                    (r_wr_ptr[DEPTH_W-1:0] == r_rd_ptr[DEPTH_W-1:0]);
  assign count_o  = r_wr_ptr - r_rd_ptr;
  assign afull_o  = (count_o >= PW'(AFULL_LVL));
  assign wr_idx_o = r_wr_ptr[DEPTH_W-1:0];
  assign rd_idx_o = r_rd_ptr[DEPTH_W-1:0];

  // A full VC still takes a write when the same VC is read this cycle:
  // the read frees the slot the write lands in. No bypass on empty.
  assign rd_acc_o = rd_req_i && !empty_o;
  assign wr_acc_o = wr_req_i && (!full_o || rd_req_i);

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_acc_o) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_acc_o) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow  <= wr_req_i && !wr_acc_o;
      r_underflow <= rd_req_i && !rd_acc_o;
    end
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// rtl/vc_fifo_bank.sv - bank of per-VC circular FIFOs with shared ports
//
// Purpose: router input buffer; one shared write port and one shared read
//          port over VC_NUM independent FIFOs of 2**DEPTH_W entries each.
// Option:  VC_FIFO_BANK_FWFT_EN selects first-word-fall-through reads
//          (data_o/valid_o show head of rd_vc_i, rd_en_i pops). Default is
//          a registered read with one cycle of latency.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   wr_en_i, wr_vc_i, data_i           write request, target VC, flit
//   rd_en_i, rd_vc_i                   read request, source VC
//   data_o, valid_o                    read flit and its qualifier
//   full_o, empty_o, afull_o, count_o  per-VC status (VC0 in LSBs)
//   overflow_o, underflow_o            per-VC rejected-request pulses
module vc_fifo_bank
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH_W    = 2,
  parameter int VC_NUM     = 2,
  parameter int AFULL_LVL  = 3,
  localparam int VC_W      = vc_w(VC_NUM),
  localparam int CNT_W     = DEPTH_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [VC_W-1:0]         wr_vc_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    rd_en_i,
  input  logic [VC_W-1:0]         rd_vc_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  output logic [VC_NUM-1:0]       full_o,
  output logic [VC_NUM-1:0]       empty_o,
  output logic [VC_NUM-1:0]       afull_o,
  output logic [VC_NUM*CNT_W-1:0] count_o,
  output logic [VC_NUM-1:0]       overflow_o,
  output logic [VC_NUM-1:0]       underflow_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int AW    = vc_w(VC_NUM * DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [VC_NUM*DEPTH];

  logic [VC_NUM-1:0]  w_wr_req;
  logic [VC_NUM-1:0]  w_rd_req;
  logic [VC_NUM-1:0]  w_wr_acc;
  logic [VC_NUM-1:0]  w_rd_acc;
  logic [DEPTH_W-1:0] w_wr_idx [VC_NUM];
  logic [DEPTH_W-1:0] w_rd_idx [VC_NUM];
  logic [AW-1:0]      w_wr_addr;
  logic [AW-1:0]      w_rd_addr;

  // Decode requests per VC. A VC id >= VC_NUM matches nothing, so the
  // request is silently dropped with no error pulse.
  always_comb begin
    w_wr_req  = '0;
    w_rd_req  = '0;
    w_wr_addr = '0;
    w_rd_addr = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_vc_i == VC_W'(v)) begin
        w_wr_req[v] = wr_en_i;
        w_wr_addr   = AW'(v * DEPTH) + AW'(w_wr_idx[v]);
      end
      if (rd_vc_i == VC_W'(v)) begin
        w_rd_req[v] = rd_en_i;
        w_rd_addr   = AW'(v * DEPTH) + AW'(w_rd_idx[v]);
      end
    end
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    vc_fifo_ctrl #(
      .DEPTH_W   (DEPTH_W),
      .AFULL_LVL (AFULL_LVL)
    ) u_ctrl (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_req_i    (w_wr_req[g]),
      .rd_req_i    (w_rd_req[g]),
      .wr_acc_o    (w_wr_acc[g]),
      .rd_acc_o    (w_rd_acc[g]),
      .wr_idx_o    (w_wr_idx[g]),
      .rd_idx_o    (w_rd_idx[g]),
      .full_o      (full_o[g]),
      .empty_o     (empty_o[g]),
      .afull_o     (afull_o[g]),
      .count_o     (count_o[g*CNT_W +: CNT_W]),
      .overflow_o  (overflow_o[g]),
      .underflow_o (underflow_o[g])
    );
  end

  // Storage is deliberately not reset; only the pointers define contents.
  always_ff @(posedge clk_i) begin
    if (|w_wr_acc) r_mem[w_wr_addr] <= data_i;
  end

`ifdef VC_FIFO_BANK_FWFT_EN
  logic w_rd_hit;
  logic w_rd_empty;

  always_comb begin
    w_rd_hit   = 1'b0;
    w_rd_empty = 1'b1;
    for (int v = 0; v < VC_NUM; v++) begin
      if (rd_vc_i == VC_W'(v)) begin
        w_rd_hit   = 1'b1;
        w_rd_empty = empty_o[v];
      end
    end
  end

  assign data_o  = w_rd_hit ? r_mem[w_rd_addr] : '0;
  assign valid_o = w_rd_hit && !w_rd_empty;
`else
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // When a full VC is read and written in the same cycle the write targets
  // the head slot; the non-blocking read still returns the old head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (|w_rd_acc) begin
      r_data  <= r_mem[w_rd_addr];
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`endif

endmodule
